// File: rtl/garage_door_ctrl_param_if.sv
// Signal bundle between the door sensors / remote receiver and the door controller.
// The master side drives the sensor and button levels; the slave side is the controller.
interface garage_door_ctrl_param_if;
    logic       remote;
    logic       open;
    logic       closed;
    logic       obstacle;
    logic       clear_fault;
    logic       power;
    logic       direction;
    logic       fault;
    logic [2:0] door_state;

    modport master (
        output remote, open, closed, obstacle, clear_fault,
        input  power, direction, fault, door_state
    );

    modport slave (
        input  remote, open, closed, obstacle, clear_fault,
        output power, direction, fault, door_state
    );
endinterface

// File: rtl/garage_door_ctrl_param.sv
// Garage door controller with internal auto-close timer, motor-run watchdog,
// obstacle auto-reverse, latched fault state and rising-edge remote detection.
module garage_door_ctrl_param #(
    parameter int AUTO_CLOSE_CYCLES = 8,
    parameter int MOVE_LIMIT_CYCLES = 16,
    parameter int CNT_W             = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    garage_door_ctrl_param_if.slave bus
);

    typedef enum logic [2:0] {
        ST_CLOSED      = 3'b000,
        ST_OPENING     = 3'b001,
        ST_OPEN        = 3'b010,
        ST_PAUSE_OPEN  = 3'b011,
        ST_CLOSING     = 3'b100,
        ST_PAUSE_CLOSE = 3'b101,
        ST_FAULT       = 3'b110
    } state_t;

    localparam logic [CNT_W-1:0] AUTO_LAST = CNT_W'(AUTO_CLOSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(MOVE_LIMIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt;
    logic               remote_q;
    logic               press;
    logic               sensor_err;
    logic               hold_cnt;
    logic               power;
    logic               direction;
    logic               fault;

    // remote_q resets high so a button held through reset needs a fresh press
    assign press      = bus.remote & ~remote_q;
    assign sensor_err = bus.open & bus.closed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_CLOSED;
            cnt      <= '0;
            remote_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            remote_q <= bus.remote;
            if ((state_d != state_q) || hold_cnt) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        hold_cnt = 1'b0;
        if (sensor_err && (state_q != ST_FAULT)) begin
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_CLOSED: begin
                    if (press) state_d = ST_OPENING;
                end
                ST_OPENING: begin
                    if (bus.open)              state_d = ST_OPEN;
                    else if (press)            state_d = ST_PAUSE_OPEN;
                    else if (cnt == MOVE_LAST) state_d = ST_FAULT;
                end
                ST_PAUSE_OPEN: begin
                    if (press) state_d = ST_OPENING;
                end
                ST_OPEN: begin
                    if (press)                 state_d  = ST_CLOSING;
                    else if (bus.obstacle)     hold_cnt = 1'b1;
                    else if (cnt == AUTO_LAST) state_d  = ST_CLOSING;
                end
                ST_CLOSING: begin
                    // obstacle outranks the closed sensor: reversing is always safe
                    if (bus.obstacle)          state_d = ST_OPENING;
                    else if (bus.closed)       state_d = ST_CLOSED;
                    else if (press)            state_d = ST_PAUSE_CLOSE;
                    else if (cnt == MOVE_LAST) state_d = ST_FAULT;
                end
                ST_PAUSE_CLOSE: begin
                    if (press) state_d = ST_CLOSING;
                end
                ST_FAULT: begin
                    if (bus.clear_fault && !sensor_err)
                        state_d = bus.closed ? ST_CLOSED : ST_PAUSE_OPEN;
                end
                default: state_d = ST_CLOSED;
            endcase
        end
    end

    always_comb begin
        power     = 1'b0;
        direction = 1'b0;
        fault     = 1'b0;
        case (state_q)
            ST_OPENING: power = 1'b1;
            ST_CLOSING: begin
                power     = 1'b1;
                direction = 1'b1;
            end
            ST_FAULT:   fault = 1'b1;
            default:    ;
        endcase
    end

    assign bus.power      = power;
    assign bus.direction  = direction;
    assign bus.fault      = fault;
    assign bus.door_state = state_q;

endmodule

// File: tb/tb_garage_door_ctrl_param.sv
// Directed bench for garage_door_ctrl_param with hand-computed expected states.
module tb_garage_door_ctrl_param;

    localparam logic [2:0] S_CLOSED = 3'b000, S_OPENING = 3'b001, S_OPEN = 3'b010,
                           S_PO = 3'b011, S_CLOSING = 3'b100, S_PC = 3'b101, S_FAULT = 3'b110;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    garage_door_ctrl_param_if dif ();

    garage_door_ctrl_param #(
        .AUTO_CLOSE_CYCLES(8),
        .MOVE_LIMIT_CYCLES(16),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(dif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // door_state plus the Moore outputs expected for that state
    task automatic chk_state(input string tag, input logic [2:0] st);
        chk({tag, ".state"}, {5'd0, dif.door_state}, {5'd0, st});
        chk({tag, ".power"}, {7'd0, dif.power}, {7'd0, (st == S_OPENING) || (st == S_CLOSING)});
        chk({tag, ".dir"},   {7'd0, dif.direction}, {7'd0, st == S_CLOSING});
        chk({tag, ".fault"}, {7'd0, dif.fault}, {7'd0, st == S_FAULT});
    endtask

    initial begin
        dif.remote = 1'b0; dif.open = 1'b0; dif.closed = 1'b0;
        dif.obstacle = 1'b0; dif.clear_fault = 1'b0;
        tick(2);
        chk_state("reset", S_CLOSED);
        rst_n = 1'b1;
        tick(1);

        // full cycle
        dif.remote = 1'b1; tick(1); chk_state("press_open", S_OPENING);
        dif.remote = 1'b0; tick(4); chk_state("opening_c4", S_OPENING);
        dif.open = 1'b1;   tick(1); chk_state("reach_open", S_OPEN);
        tick(7);                    chk_state("open_c7", S_OPEN);
        tick(1);                    chk_state("auto_close", S_CLOSING);
        dif.open = 1'b0; dif.closed = 1'b1; tick(1); chk_state("reach_closed", S_CLOSED);

        // pause / resume while opening
        dif.remote = 1'b1; tick(1); chk_state("pr_open", S_OPENING);
        dif.closed = 1'b0; dif.remote = 1'b0; tick(1);
        dif.remote = 1'b1; tick(1); chk_state("pause_open", S_PO);
        tick(10);                   chk_state("held_paused", S_PO);
        dif.remote = 1'b0; tick(1);
        dif.remote = 1'b1; tick(1); chk_state("resume", S_OPENING);
        dif.remote = 1'b0; dif.open = 1'b1; tick(1); chk_state("open2", S_OPEN);

        // obstacle holds off auto-close; closing resumes 8 cycles after release
        dif.obstacle = 1'b1; tick(20); chk_state("obst_hold", S_OPEN);
        dif.obstacle = 1'b0; tick(7);  chk_state("obst_rel7", S_OPEN);
        dif.open = 1'b0;     tick(1);  chk_state("obst_rel8", S_CLOSING);
        dif.obstacle = 1'b1; tick(1);  chk_state("auto_reverse", S_OPENING);
        dif.obstacle = 1'b0; dif.open = 1'b1; tick(1); chk_state("open3", S_OPEN);
        dif.open = 1'b0; dif.remote = 1'b1; tick(1); chk_state("press_close", S_CLOSING);
        dif.remote = 1'b0; dif.obstacle = 1'b1; dif.closed = 1'b1; tick(1);
        chk_state("obst_and_closed", S_OPENING);
        dif.obstacle = 1'b0; dif.closed = 1'b0;
        dif.remote = 1'b1; dif.open = 1'b1; tick(1); chk_state("press_and_open", S_OPEN);
        dif.remote = 1'b0; dif.open = 1'b0; tick(1);

        // pause while closing ignores obstacle, then closing watchdog
        dif.remote = 1'b1; tick(1); chk_state("close4", S_CLOSING);
        dif.remote = 1'b0; tick(1);
        dif.remote = 1'b1; tick(1); chk_state("pause_close", S_PC);
        dif.remote = 1'b0; dif.obstacle = 1'b1; tick(1); chk_state("pc_obst", S_PC);
        dif.obstacle = 1'b0; dif.remote = 1'b1; tick(1); chk_state("resume_close", S_CLOSING);
        dif.remote = 1'b0; tick(15); chk_state("wd_close15", S_CLOSING);
        tick(1);                     chk_state("wd_close16", S_FAULT);
        dif.remote = 1'b1; tick(1);  chk_state("fault_press", S_FAULT);
        dif.remote = 1'b0; dif.clear_fault = 1'b1; tick(1); chk_state("clr_to_po", S_PO);
        dif.clear_fault = 1'b0;

        // opening watchdog
        dif.remote = 1'b1; tick(1); chk_state("wd_open0", S_OPENING);
        dif.remote = 1'b0; tick(15); chk_state("wd_open15", S_OPENING);
        tick(1);                     chk_state("wd_open16", S_FAULT);
        dif.closed = 1'b1; dif.clear_fault = 1'b1; tick(1); chk_state("clr_to_closed", S_CLOSED);
        dif.clear_fault = 1'b0;

        // sensor conflict
        dif.open = 1'b1; tick(1); chk_state("conflict", S_FAULT);
        dif.clear_fault = 1'b1; tick(1); chk_state("conflict_clr", S_FAULT);
        dif.open = 1'b0; tick(1); chk_state("conflict_gone", S_CLOSED);
        dif.clear_fault = 1'b0; dif.closed = 1'b0;

        // asynchronous reset mid-closing, remote held across release
        dif.remote = 1'b1; tick(1); chk_state("ar_opening", S_OPENING);
        dif.remote = 1'b0; dif.open = 1'b1; tick(1);
        dif.open = 1'b0; dif.remote = 1'b1; tick(1); chk_state("ar_closing", S_CLOSING);
        #2 rst_n = 1'b0;
        #1 chk_state("async_rst", S_CLOSED);
        #2 rst_n = 1'b1;
        tick(2); chk_state("held_remote", S_CLOSED);
        dif.remote = 1'b0; tick(1);
        dif.remote = 1'b1; tick(1); chk_state("repress", S_OPENING);
        dif.remote = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
